rot_param_ctrl: RTL and testbench
=================================

ROT_PARAM_CTRL -- requirements
Module: rot_param_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of each stored value.
REQ-002 SHALL have parameter MAXV, default 255: upper saturation limit for edited values; MAXV < 2^WIDTH.
REQ-003 SHALL have parameter INITV, default 0: reset value of all four stored values; INITV <= MAXV.
REQ-004 SHALL have parameter STEP_FAST, default 4: step size applied while accelerated.
REQ-005 SHALL have parameter FAST_WIN, default 500000: pulse spacing in clk cycles below which acceleration applies.
REQ-006 SHALL have parameter TIMEOUT, default 250000000: idle cycles in EDIT before abort.
REQ-007 SHALL have port clk, input, 1: clock, rising edge.
REQ-008 SHALL have port nrst, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port rotated, input, 1: one-cycle pulse per encoder detent.
REQ-010 SHALL have port dir, input, 1: direction qualifying rotated; 1 = cw/increment, 0 = ccw/decrement.
REQ-011 SHALL have port press, input, 1: one-cycle debounced push-button pulse.
REQ-012 SHALL have port sel, output, 2: index of the selected value (0..3).
REQ-013 SHALL have port editing, output, 1: high while in EDIT.
REQ-014 SHALL have port cur_val, output, WIDTH: shadow value in EDIT; stored value[sel] otherwise.
REQ-015 SHALL have port vals, output, 4*WIDTH: stored values; value[i] at bits [i*WIDTH +: WIDTH].
REQ-016 SHALL have port upd, output, 1: one-cycle pulse when a value is committed.
REQ-017 SHALL have port abort, output, 1: one-cycle pulse when an edit times out.

Function
REQ-018 SHALL implement FSM states BROWSE, EDIT and COMMIT; all outputs SHALL be registered.
REQ-019 BROWSE: rotated with dir=1 SHALL set sel to sel+1 mod 4, and with dir=0 to sel-1 mod 4, on the next cycle.
REQ-020 BROWSE: press SHALL load shadow with value[sel], clear the idle and spacing counters, and enter EDIT; editing SHALL be high the next cycle.
REQ-021 EDIT: rotated SHALL add (dir=1) or subtract (dir=0) a step from shadow; sel SHALL stay frozen.
REQ-022 Step SHALL be STEP_FAST if the previous accepted pulse in the same EDIT was fewer than FAST_WIN cycles earlier, else 1; the first pulse after entering EDIT SHALL use step 1.
REQ-023 Increment SHALL saturate at MAXV and decrement SHALL saturate at 0; arithmetic SHALL use WIDTH+1 bits with no wrap-around.
REQ-024 The spacing counter SHALL saturate at FAST_WIN and SHALL reset to 0 on every accepted pulse.
REQ-025 EDIT: press SHALL enter COMMIT.
REQ-026 COMMIT SHALL last exactly one cycle: write shadow to value[sel], pulse upd for one cycle, and return to BROWSE.
REQ-027 EDIT: the idle counter SHALL reset on rotated or press; on reaching TIMEOUT-1 with no event, the FSM SHALL discard shadow, pulse abort, and return to BROWSE with the stored value unchanged.
REQ-028 If rotated and press arrive in the same cycle, press SHALL take priority and the rotation SHALL be dropped, in both BROWSE and EDIT.
REQ-029 In COMMIT, rotated and press SHALL be ignored.
REQ-030 upd and abort SHALL never be high in the same cycle.

Reset
REQ-031 nrst low SHALL immediately force: state BROWSE, sel=0, editing=0, upd=0, abort=0, all values=INITV, shadow=INITV, cur_val=INITV, all counters=0.
REQ-032 Reset asserted mid-EDIT SHALL discard the edit, with no upd or abort pulse.

Verification (bench: WIDTH=8, MAXV=200, INITV=10, STEP_FAST=4, FAST_WIN=8, TIMEOUT=50)
REQ-033 Four cw pulses in BROWSE, then one ccw pulse -> sel sequence 1,2,3,0,3.
REQ-034 press; two cw pulses 20 cycles apart; press -> cur_val 11, then 12; upd pulses once; value[sel]=12; editing low afterwards.
REQ-035 press; three cw pulses 3 cycles apart from value 10 -> cur_val 11, 15, 19; then ccw pulses at 3-cycle spacing from 3 -> values 0 and 0 (floor saturation, no wrap); near MAXV, 198 plus a fast cw pulse -> 200.
REQ-036 press; one rotation; then 50 idle cycles -> abort pulses once; value unchanged; state BROWSE; upd stays low.
REQ-037 rotated and press in the same cycle in BROWSE -> sel unchanged and EDIT entered; same event in EDIT -> shadow unchanged and commit occurs.
REQ-038 nrst pulsed low mid-EDIT after value 14 was committed to value[2] -> all outputs return to reset values, including vals = INITV for every value, with no upd or abort pulse.

Source files
------------

// File: rtl/rot_param_ctrl.sv
// rot_param_ctrl: rotary-encoder browse/edit controller for four saturating stored values
module rot_param_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MAXV      = 255,
  parameter int INITV     = 0,
  parameter int STEP_FAST = 4,
  parameter int FAST_WIN  = 500000,
  parameter int TIMEOUT   = 250000000
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               rotated,
  input  logic               dir,
  input  logic               press,
  output logic [1:0]         sel,
  output logic               editing,
  output logic [WIDTH-1:0]   cur_val,
  output logic [4*WIDTH-1:0] vals,
  output logic               upd,
  output logic               abort
);
  localparam int W1 = WIDTH + 1;
  localparam int GW = $clog2(FAST_WIN + 1);
  localparam int IW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {BROWSE, EDIT, COMMIT} state_t;
  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] shadow_q, shadow_d, cur_q, cur_d;
  logic [WIDTH-1:0] vals_q [4];
  logic [WIDTH-1:0] vals_d [4];
  logic [GW-1:0]    gap_q, gap_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             prev_q, prev_d, edit_q, edit_d, upd_q, upd_d, abort_q, abort_d;
  logic [WIDTH:0]   step, sum, diff;
  logic [WIDTH-1:0] inc, dec;
  // step 1 unless an earlier pulse of this edit landed fewer than FAST_WIN cycles ago
  assign step = (prev_q && gap_q < GW'(FAST_WIN - 1)) ? W1'(STEP_FAST) : W1'(1);
  assign sum  = {1'b0, shadow_q} + step;
  assign diff = {1'b0, shadow_q} - step;
  assign inc  = sum > W1'(MAXV) ? WIDTH'(MAXV) : sum[WIDTH-1:0];
  assign dec  = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    vals_d   = vals_q;
    gap_d    = gap_q == GW'(FAST_WIN) ? gap_q : gap_q + GW'(1);
    idle_d   = idle_q;
    prev_d   = prev_q;
    upd_d    = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      BROWSE: begin
        if (press) begin
          state_d  = EDIT;
          shadow_d = vals_q[sel_q];
          gap_d    = '0;
          idle_d   = '0;
          prev_d   = 1'b0;
        end else if (rotated) sel_d = dir ? sel_q + 2'd1 : sel_q - 2'd1;
      end
      EDIT: begin
        if (press) begin
          state_d = COMMIT;
          idle_d  = '0;
        end else if (rotated) begin
          shadow_d = dir ? inc : dec;
          gap_d    = '0;
          idle_d   = '0;
          prev_d   = 1'b1;
        end else if (idle_q == IW'(TIMEOUT - 1)) begin
          state_d = BROWSE;
          abort_d = 1'b1;
        end else idle_d = idle_q + IW'(1);
      end
      COMMIT: begin
        vals_d[sel_q] = shadow_q;
        upd_d         = 1'b1;
        state_d       = BROWSE;
      end
      default: state_d = BROWSE;
    endcase
    edit_d = state_d == EDIT;
    cur_d  = edit_d ? shadow_d : vals_d[sel_d];
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= BROWSE;
      sel_q    <= '0;
      shadow_q <= WIDTH'(INITV);
      vals_q   <= '{default: WIDTH'(INITV)};
      gap_q    <= '0;
      idle_q   <= '0;
      prev_q   <= 1'b0;
      edit_q   <= 1'b0;
      upd_q    <= 1'b0;
      abort_q  <= 1'b0;
      cur_q    <= WIDTH'(INITV);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      vals_q   <= vals_d;
      gap_q    <= gap_d;
      idle_q   <= idle_d;
      prev_q   <= prev_d;
      edit_q   <= edit_d;
      upd_q    <= upd_d;
      abort_q  <= abort_d;
      cur_q    <= cur_d;
    end
  end
  assign sel     = sel_q;
  assign editing = edit_q;
  assign cur_val = cur_q;
  assign upd     = upd_q;
  assign abort   = abort_q;
  for (genvar i = 0; i < 4; i++) begin : g_vals
    assign vals[i*WIDTH +: WIDTH] = vals_q[i];
  end
endmodule

// File: tb/tb_rot_param_ctrl.sv
// tb_rot_param_ctrl: vector table, corner sequences and random traffic against an event-time model
module tb_rot_param_ctrl;
  localparam int WIDTH = 8, MAXV = 200, INITV = 10, STEP_FAST = 4, FAST_WIN = 8, TIMEOUT = 50;
  logic clk = 1'b0, nrst = 1'b0, rotated = 1'b0, dir = 1'b0, press = 1'b0;
  logic [1:0] sel;
  logic editing, upd, abort;
  logic [WIDTH-1:0] cur_val;
  logic [4*WIDTH-1:0] vals;
  int vecs = 0, errs = 0;

  rot_param_ctrl #(.WIDTH(WIDTH), .MAXV(MAXV), .INITV(INITV), .STEP_FAST(STEP_FAST),
                   .FAST_WIN(FAST_WIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .rotated(rotated), .dir(dir), .press(press), .sel(sel),
    .editing(editing), .cur_val(cur_val), .vals(vals), .upd(upd), .abort(abort));

  always #5 clk = ~clk;

  // model: time-stamped events rather than counters
  int m_sel, m_shadow, m_cyc, m_last_pulse, m_last_event;
  int m_vals[4];
  bit m_edit, m_commit, m_upd, m_abort;

  task automatic model_reset();
    m_sel = 0; m_shadow = INITV; m_cyc = 0; m_last_pulse = -1; m_last_event = 0;
    m_edit = 0; m_commit = 0; m_upd = 0; m_abort = 0;
    for (int i = 0; i < 4; i++) m_vals[i] = INITV;
  endtask

  task automatic model(input bit r, input bit d, input bit p);
    int step;
    m_cyc++; m_upd = 0; m_abort = 0;
    if (m_commit) begin
      m_vals[m_sel] = m_shadow; m_upd = 1; m_commit = 0;
    end else if (!m_edit) begin
      if (p) begin
        m_edit = 1; m_shadow = m_vals[m_sel]; m_last_pulse = -1; m_last_event = m_cyc;
      end else if (r) m_sel = (m_sel + (d ? 1 : 3)) % 4;
    end else if (p) begin
      m_edit = 0; m_commit = 1;
    end else if (r) begin
      step = (m_last_pulse >= 0 && m_cyc - m_last_pulse < FAST_WIN) ? STEP_FAST : 1;
      m_shadow = d ? ((m_shadow + step > MAXV) ? MAXV : m_shadow + step)
                   : ((m_shadow - step < 0) ? 0 : m_shadow - step);
      m_last_pulse = m_cyc; m_last_event = m_cyc;
    end else if (m_cyc - m_last_event >= TIMEOUT) begin
      m_edit = 0; m_abort = 1;
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [44:0] model_out();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(m_vals[i]);
    return {2'(m_sel), m_edit, 8'(m_edit ? m_shadow : m_vals[m_sel]), v, m_upd, m_abort};
  endfunction

  task automatic tick(input bit r, input bit d, input bit p);
    rotated = r; dir = d; press = p;
    @(posedge clk);
    model(r, d, p);
    @(negedge clk);
    rotated = 1'b0; press = 1'b0;
    check("model", 64'({sel, editing, cur_val, vals, upd, abort}), 64'(model_out()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  task automatic do_reset();
    #2 nrst = 1'b0;
    #1 check("reset_outputs", 64'({sel, editing, cur_val, vals, upd, abort}),
             64'({2'd0, 1'b0, 8'(INITV), {4{8'(INITV)}}, 1'b0, 1'b0}));
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int idle; bit r, d, p; int esel; bit eed; int ecur; bit eupd;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl = '{
      '{0,1,1,0,1,0,10,0}, '{0,1,1,0,2,0,10,0}, '{0,1,1,0,3,0,10,0}, '{0,1,1,0,0,0,10,0},
      '{0,1,0,0,3,0,10,0}, '{0,0,0,1,3,1,10,0}, '{0,1,1,0,3,1,11,0}, '{19,1,1,0,3,1,12,0},
      '{0,0,0,1,3,0,10,0}, '{0,0,0,0,3,0,12,1}, '{0,0,0,0,3,0,12,0}, '{0,1,0,0,2,0,10,0},
      '{0,0,0,1,2,1,10,0}, '{0,1,1,0,2,1,11,0}, '{2,1,1,0,2,1,15,0}, '{2,1,1,0,2,1,19,0},
      '{0,0,0,1,2,0,10,0}, '{0,0,0,0,2,0,19,1}, '{0,0,0,1,2,1,19,0}, '{0,1,1,0,2,1,20,0},
      '{2,1,0,0,2,1,16,0}, '{2,1,0,0,2,1,12,0}, '{2,1,0,0,2,1,8,0},  '{2,1,0,0,2,1,4,0},
      '{10,1,0,0,2,1,3,0}, '{2,1,0,0,2,1,0,0},  '{2,1,0,0,2,1,0,0}};
    #12 check("reset_outputs", 64'({sel, editing, cur_val, vals, upd, abort}),
              64'({2'd0, 1'b0, 8'(INITV), {4{8'(INITV)}}, 1'b0, 1'b0}));
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    foreach (tbl[k]) begin
      idle(tbl[k].idle);
      tick(tbl[k].r, tbl[k].d, tbl[k].p);
      check($sformatf("row%0d", k), 64'({sel, editing, cur_val, upd, abort}),
            64'({2'(tbl[k].esel), tbl[k].eed, 8'(tbl[k].ecur), tbl[k].eupd, 1'b0}));
    end
    // ceiling saturation: fast climb to 196, slow to 198, one fast pulse clips at MAXV
    for (int i = 0; i < 49; i++) begin idle(2); tick(1, 1, 0); end
    check("climb_196", 64'(cur_val), 64'd196);
    idle(9); tick(1, 1, 0);
    idle(9); tick(1, 1, 0);
    check("slow_198", 64'(cur_val), 64'd198);
    idle(2); tick(1, 1, 0);
    check("sat_max", 64'(cur_val), 64'(MAXV));
    idle(2); tick(1, 1, 0);
    check("sat_max_hold", 64'(cur_val), 64'(MAXV));
    tick(0, 0, 1); tick(0, 0, 0);
    check("commit_200", 64'({upd, vals[23:16]}), 64'({1'b1, 8'd200}));
    // edit timeout
    tick(0, 0, 1); tick(1, 0, 0);
    check("edit_199", 64'(cur_val), 64'd199);
    idle(49);
    check("pre_timeout", 64'({editing, abort}), 64'b10);
    tick(0, 0, 0);
    check("timeout_abort", 64'({editing, abort, upd, cur_val}), 64'({1'b0, 1'b1, 1'b0, 8'd200}));
    tick(0, 0, 0);
    check("abort_one_cycle", 64'(abort), 64'd0);
    // rotation and press together
    tick(1, 1, 1);
    check("coll_browse", 64'({sel, editing, cur_val}), 64'({2'd2, 1'b1, 8'd200}));
    tick(1, 0, 1);
    check("coll_edit", 64'(editing), 64'd0);
    tick(0, 0, 0);
    check("coll_commit", 64'({upd, vals[23:16]}), 64'({1'b1, 8'd200}));
    // reset in the middle of an edit
    do_reset();
    tick(1, 1, 0); tick(1, 1, 0); tick(0, 0, 1); tick(1, 1, 0);
    idle(2); tick(1, 1, 0); idle(10); tick(1, 0, 0);
    tick(0, 0, 1); tick(0, 0, 0);
    check("commit_14", 64'({upd, vals[23:16]}), 64'({1'b1, 8'd14}));
    tick(0, 0, 1); tick(1, 1, 0);
    check("mid_edit", 64'({editing, cur_val}), 64'({1'b1, 8'd15}));
    do_reset();
    idle(3);
    check("post_reset", 64'({sel, editing, cur_val, vals, upd, abort}),
          64'({2'd0, 1'b0, 8'(INITV), {4{8'(INITV)}}, 1'b0, 1'b0}));
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) idle($urandom_range(40, 60));
      tick($urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 24) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
